// File: rtl/alt_vipswi131_common_handshake_ctrl.sv
// Source-side four-phase req/ack controller: holds a word stable on xfer_data,
// raises xfer_req after a setup window, and recovers from a missing ack via a timeout.
module alt_vipswi131_common_handshake_ctrl #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] xfer_data,
  output logic             xfer_req,
  input  logic             xfer_ack_sync,
  output logic             done,
  output logic             busy,
  output logic             timeout_err,
  input  logic             clear_err
);

  localparam int unsigned CNT_W      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SETUP_W    = 4;
  localparam int unsigned SETUP_LAST = (SETUP_CYCLES == 0) ? 0 : SETUP_CYCLES - 1;
  localparam bit          TO_EN      = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_REQ   = 3'd2,
    S_REL   = 3'd3,
    S_ERR   = 3'd4,
    S_RECOV = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d, wait_inc;
  logic [SETUP_W-1:0] setup_cnt_q, setup_cnt_d;
  logic               wait_hit;
  logic               accept;
  logic               done_d;
  logic               err_d;

  // A stale ack in IDLE blocks new words until the far side has released.
  assign in_ready = (state_q == S_IDLE) && !xfer_ack_sync;
  assign accept   = in_valid && in_ready;
  assign wait_inc = wait_cnt_q + CNT_W'(1);
  assign wait_hit = TO_EN && (wait_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    setup_cnt_d = setup_cnt_q;
    err_d       = timeout_err;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          setup_cnt_d = '0;
          wait_cnt_d  = '0;
          state_d     = (SETUP_CYCLES != 0) ? S_SETUP : S_REQ;
        end
      end
      S_SETUP: begin
        if (setup_cnt_q == SETUP_W'(SETUP_LAST)) begin
          state_d    = S_REQ;
          wait_cnt_d = '0;
        end else begin
          setup_cnt_d = setup_cnt_q + SETUP_W'(1);
        end
      end
      S_REQ: begin
        if (xfer_ack_sync) begin
          state_d    = S_REL;
          wait_cnt_d = '0;
        end else if (wait_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (TO_EN) begin
          wait_cnt_d = wait_inc;
        end
      end
      S_REL: begin
        if (!xfer_ack_sync) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (wait_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (TO_EN) begin
          wait_cnt_d = wait_inc;
        end
      end
      S_ERR: begin
        if (clear_err) begin
          err_d   = 1'b0;
          state_d = xfer_ack_sync ? S_RECOV : S_IDLE;
        end
      end
      S_RECOV: begin
        if (!xfer_ack_sync) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      setup_cnt_q <= '0;
      xfer_data   <= '0;
      xfer_req    <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      setup_cnt_q <= setup_cnt_d;
      xfer_req    <= (state_d == S_REQ);
      done        <= done_d;
      busy        <= (state_d != S_IDLE);
      timeout_err <= err_d;
      if (accept) xfer_data <= in_data;
    end
  end

endmodule

// File: tb/tb_alt_vipswi131_common_handshake_ctrl.sv
// Scoreboard bench: two controller instances (setup 1 / timeout 15, and setup 0 / no timeout).
module tb_alt_vipswi131_common_handshake_ctrl;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  // instance A
  logic       valid_a = 1'b0, ready_a, req_a, ack_a, done_a, busy_a, err_a, clr_a = 1'b0;
  logic [7:0] data_a = 8'h00, xdata_a;
  logic       loop_a = 1'b1, ack_force_a = 1'b0, d1a = 1'b0, d2a = 1'b0;

  // instance B
  logic       valid_b = 1'b0, ready_b, req_b, ack_b, done_b, busy_b, err_b;
  logic [7:0] data_b = 8'h00, xdata_b;
  logic       loop_b = 1'b0, d1b = 1'b0, d2b = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  always_ff @(posedge clock) begin
    d1a <= req_a; d2a <= d1a;
    d1b <= req_b; d2b <= d1b;
  end
  assign ack_a = loop_a ? d2a : ack_force_a;
  assign ack_b = loop_b ? d2b : 1'b0;

  alt_vipswi131_common_handshake_ctrl #(.WIDTH(8), .SETUP_CYCLES(1), .TIMEOUT_CYCLES(15)) dut_a (
    .clock(clock), .rst_n(rst_n), .in_valid(valid_a), .in_ready(ready_a), .in_data(data_a),
    .xfer_data(xdata_a), .xfer_req(req_a), .xfer_ack_sync(ack_a), .done(done_a),
    .busy(busy_a), .timeout_err(err_a), .clear_err(clr_a));

  alt_vipswi131_common_handshake_ctrl #(.WIDTH(8), .SETUP_CYCLES(0), .TIMEOUT_CYCLES(0)) dut_b (
    .clock(clock), .rst_n(rst_n), .in_valid(valid_b), .in_ready(ready_b), .in_data(data_b),
    .xfer_data(xdata_b), .xfer_req(req_b), .xfer_ack_sync(ack_b), .done(done_b),
    .busy(busy_b), .timeout_err(err_b), .clear_err(1'b0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done_a(input string name, input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      tick();
      if (done_a) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_done_b(input string name, input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      tick();
      if (done_b) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Monitor: every done or rising error flag consumes one expected event.
  initial begin
    logic prev_err_a = 1'b0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (rst_n) begin
        if (done_a) begin
          if (sb_a.size() == 0) check("a_done_unexpected", 32'd1, 32'd0);
          else begin
            e = sb_a.pop_front();
            check("a_done_kind", 32'd0, 32'(e.is_err));
            check("a_done_data", 32'(xdata_a), 32'(e.data));
          end
        end
        if (err_a && !prev_err_a) begin
          if (sb_a.size() == 0) check("a_err_unexpected", 32'd1, 32'd0);
          else begin
            e = sb_a.pop_front();
            check("a_err_kind", 32'd1, 32'(e.is_err));
            check("a_err_data", 32'(xdata_a), 32'(e.data));
          end
        end
        if (done_b) begin
          if (sb_b.size() == 0) check("b_done_unexpected", 32'd1, 32'd0);
          else begin
            e = sb_b.pop_front();
            check("b_done_data", 32'(xdata_b), 32'(e.data));
          end
        end
        if (err_b) check("b_err_never", 32'(err_b), 32'd0);
      end
      prev_err_a = err_a;
    end
  end

  initial begin
    bit err_seen;
    bit req_drop;

    // reset state
    rst_n = 1'b0;
    repeat (4) tick();
    rst_n = 1'b1;
    check("rst_req", 32'(req_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_xdata", 32'(xdata_a), 32'h00);
    check("rst_ready", 32'(ready_a), 32'd1);

    // 1: single transfer through the 2-cycle loopback
    valid_a = 1'b1; data_a = 8'hA5;
    sb_a.push_back('{is_err: 1'b0, data: 8'hA5});
    tick();
    valid_a = 1'b0;
    check("t1_xdata_n1", 32'(xdata_a), 32'hA5);
    check("t1_req_n1", 32'(req_a), 32'd0);
    check("t1_busy_n1", 32'(busy_a), 32'd1);
    check("t1_ready_n1", 32'(ready_a), 32'd0);
    tick();
    check("t1_req_n2", 32'(req_a), 32'd1);
    wait_done_a("t1_done_seen", 20);
    check("t1_ready_at_done", 32'(ready_a), 32'd1);
    check("t1_busy_at_done", 32'(busy_a), 32'd0);
    tick();
    check("t1_done_one_cycle", 32'(done_a), 32'd0);

    // 2: ack held low -> timeout after 15 request cycles, then clear
    loop_a = 1'b0; ack_force_a = 1'b0;
    valid_a = 1'b1; data_a = 8'hB7;
    sb_a.push_back('{is_err: 1'b1, data: 8'hB7});
    tick();
    valid_a = 1'b0;
    tick();
    check("t2_req_rise", 32'(req_a), 32'd1);
    repeat (14) tick();
    check("t2_req_still", 32'(req_a), 32'd1);
    check("t2_no_err_yet", 32'(err_a), 32'd0);
    tick();
    check("t2_req_drop", 32'(req_a), 32'd0);
    check("t2_err_set", 32'(err_a), 32'd1);
    check("t2_busy_err", 32'(busy_a), 32'd1);
    repeat (3) tick();
    check("t2_err_sticky", 32'(err_a), 32'd1);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("t2_err_clr", 32'(err_a), 32'd0);
    check("t2_busy_clr", 32'(busy_a), 32'd0);
    check("t2_no_done", 32'(done_a), 32'd0);
    tick();
    check("t2_no_done2", 32'(done_a), 32'd0);

    // 3: ack high in IDLE blocks acceptance
    ack_force_a = 1'b1;
    #1;
    check("t3_ready_low", 32'(ready_a), 32'd0);
    valid_a = 1'b1; data_a = 8'h3C;
    tick();
    check("t3_no_capture", 32'(xdata_a), 32'hB7);
    check("t3_idle", 32'(busy_a), 32'd0);
    tick();
    check("t3_no_capture2", 32'(xdata_a), 32'hB7);
    ack_force_a = 1'b0;
    loop_a = 1'b1;
    #1;
    check("t3_ready_back", 32'(ready_a), 32'd1);
    sb_a.push_back('{is_err: 1'b0, data: 8'h3C});
    tick();
    check("t3_capture", 32'(xdata_a), 32'h3C);
    check("t3_busy", 32'(busy_a), 32'd1);

    // 4: new word while busy is ignored, taken right after done
    data_a = 8'hFF;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        tick();
        if (done_a) seen = 1'b1;
        else check("t4_hold", 32'(xdata_a), 32'h3C);
      end
      check("t4_done_seen", 32'(seen), 32'd1);
    end
    check("t4_xdata_at_done", 32'(xdata_a), 32'h3C);
    tick();
    valid_a = 1'b0;
    check("t4_b2b_capture", 32'(xdata_a), 32'hFF);
    check("t4_b2b_busy", 32'(busy_a), 32'd1);
    tick();
    check("t5_in_req", 32'(req_a), 32'd1);

    // 5: reset mid-request abandons the word
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_req", 32'(req_a), 32'd0);
    check("t5_busy", 32'(busy_a), 32'd0);
    check("t5_xdata", 32'(xdata_a), 32'h00);
    check("t5_err", 32'(err_a), 32'd0);
    check("t5_done", 32'(done_a), 32'd0);
    repeat (5) tick();
    check("t5_no_done_later", 32'(done_a), 32'd0);

    // 6: no setup, timeout disabled, long ack stall
    valid_b = 1'b1; data_b = 8'h5A;
    sb_b.push_back('{is_err: 1'b0, data: 8'h5A});
    tick();
    valid_b = 1'b0;
    check("t6_req_n1", 32'(req_b), 32'd1);
    check("t6_xdata", 32'(xdata_b), 32'h5A);
    err_seen = 1'b0;
    req_drop = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (err_b) err_seen = 1'b1;
      if (!req_b) req_drop = 1'b1;
    end
    check("t6_never_err", 32'(err_seen), 32'd0);
    check("t6_req_held", 32'(req_drop), 32'd0);
    check("t6_busy", 32'(busy_b), 32'd1);
    loop_b = 1'b1;
    wait_done_b("t6_done_seen", 20);
    tick();
    check("t6_idle", 32'(busy_b), 32'd0);

    repeat (3) tick();
    check("sb_a_empty", 32'(sb_a.size()), 32'd0);
    check("sb_b_empty", 32'(sb_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
